// File: rtl/fifo_ram_ctrl_if.sv
// Push/pop request and RAM-control bundle for fifo_ram_ctrl.
// Master = producer/consumer side, slave = the FIFO controller.
interface fifo_ram_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned CW = ADDR_WIDTH + 1;

    logic                  push;
    logic                  pop;
    logic                  wr;
    logic                  rd;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output push, pop,
        input  wr, rd, w_addr, r_addr, rd_valid, full, empty, count,
               overflow, underflow, almost_full, almost_empty
    );

    modport slave (
        input  push, pop,
        output wr, rd, w_addr, r_addr, rd_valid, full, empty, count,
               overflow, underflow, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// Control unit turning a dual-port 2**ADDR_WIDTH x 8 RAM into a synchronous FIFO.
// Optional almost_full/almost_empty decode enabled by defining FIFO_ALMOST_FLAGS_EN.
module fifo_ram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned AFULL_TH   = 240,
    parameter int unsigned AEMPTY_TH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    fifo_ram_ctrl_if.slave      bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    // Thresholds beyond the RAM depth would make a flag unreachable or stuck.
    if (AFULL_TH > DEPTH || AEMPTY_TH > DEPTH) begin : g_bad_th
        $error("fifo_ram_ctrl: almost thresholds exceed DEPTH");
    end

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    // Status decoded purely from the registered count, so glitch-free.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Accept decisions use current state only; no bypass through a simultaneous op.
    assign w_wr = bus.push & ~w_full;
    assign w_rd = bus.pop  & ~w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + ADDR_WIDTH'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + ADDR_WIDTH'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // RAM registers r_data on the same edge, so valid follows rd by one cycle.
            r_rd_valid  <= w_rd;
            r_overflow  <= r_overflow  | (bus.push & w_full);
            r_underflow <= r_underflow | (bus.pop  & w_empty);
        end
    end

    assign bus.wr        = w_wr;
    assign bus.rd        = w_rd;
    assign bus.w_addr    = r_wptr;
    assign bus.r_addr    = r_rptr;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

`ifdef FIFO_ALMOST_FLAGS_EN
    assign bus.almost_full  = (r_count >= CW'(AFULL_TH));
    assign bus.almost_empty = (r_count <= CW'(AEMPTY_TH));
`else
    assign bus.almost_full  = 1'b0;
    assign bus.almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl: behavioural RAM plus a queue-based FIFO model.
module tb_fifo_ram_ctrl;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;

    logic clk;
    logic reset;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic [7:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    int  wcnt, rcnt;
    bit  m_ovf, m_unf, m_rv;
    logic [7:0] m_rdata;

    fifo_ram_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_ram_ctrl #(.ADDR_WIDTH(AW), .AFULL_TH(240), .AEMPTY_TH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port RAM with registered read data
    always @(posedge clk) begin
        if (bus.wr) mem[bus.w_addr] <= w_data;
        if (bus.rd) r_data <= mem[bus.r_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive after negedge, check accept strobes, update model at posedge, check state at next negedge.
    task automatic step(input bit p, input bit q, input logic [7:0] d, input bit rst);
        bit exp_wr, exp_rd, was_full, was_empty;
        bit exp_af, exp_ae;
        bus.push = p;
        bus.pop  = q;
        w_data   = d;
        reset    = rst;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        exp_wr = p && !was_full;
        exp_rd = q && !was_empty;
        #1;
        check("wr", 32'(bus.wr), 32'(exp_wr));
        check("rd", 32'(bus.rd), 32'(exp_rd));
        @(posedge clk);
        if (rst) begin
            mq.delete();
            wcnt = 0; rcnt = 0;
            m_ovf = 0; m_unf = 0; m_rv = 0;
        end else begin
            if (exp_rd) begin
                m_rdata = mq.pop_front();
                rcnt++;
            end
            if (exp_wr) begin
                mq.push_back(d);
                wcnt++;
            end
            m_rv  = exp_rd;
            m_ovf = m_ovf | (p && was_full);
            m_unf = m_unf | (q && was_empty);
        end
        @(negedge clk);
        check("count",     32'(bus.count),     32'(mq.size()));
        check("full",      32'(bus.full),      32'(mq.size() == DEPTH));
        check("empty",     32'(bus.empty),     32'(mq.size() == 0));
        check("w_addr",    32'(bus.w_addr),    32'(wcnt % DEPTH));
        check("r_addr",    32'(bus.r_addr),    32'(rcnt % DEPTH));
        check("rd_valid",  32'(bus.rd_valid),  32'(m_rv));
        check("overflow",  32'(bus.overflow),  32'(m_ovf));
        check("underflow", 32'(bus.underflow), 32'(m_unf));
        if (m_rv) check("r_data", 32'(r_data), 32'(m_rdata));
`ifdef FIFO_ALMOST_FLAGS_EN
        exp_af = (mq.size() >= 240);
        exp_ae = (mq.size() <= 16);
`else
        exp_af = 0;
        exp_ae = 0;
`endif
        check("almost_full",  32'(bus.almost_full),  32'(exp_af));
        check("almost_empty", 32'(bus.almost_empty), 32'(exp_ae));
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        w_data   = 8'h00;
        reset    = 1'b1;
        wcnt = 0; rcnt = 0; m_ovf = 0; m_unf = 0; m_rv = 0; m_rdata = 8'h00;
        @(negedge clk);

        // Reset then idle
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0);

        // Push three known bytes, pop them back
        step(1, 0, 8'hA1, 0);
        step(1, 0, 8'hA2, 0);
        step(1, 0, 8'hA3, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Fill to full from reset, overflow attempt, drain across the address wrap
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 256; i++) step(1, 0, 8'($urandom), 0);
        step(1, 0, 8'h5A, 0);
        step(1, 1, 8'h5B, 0);
        for (int i = 0; i < 256; i++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Steady-state simultaneous push+pop at count 10, then push+pop when empty
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 20; i++) step(1, 1, 8'($urandom), 0);
        for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 0);
        step(1, 1, 8'hC3, 0);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Reset mid-stream while pushing
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 100; i++) step(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 200; i++) step(1, 0, 8'($urandom), 0);
        step(1, 0, 8'h77, 1);
        step(0, 0, 8'h00, 0);

        // Cross almost thresholds: fill to 240, drain to 16
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 240; i++) step(1, 0, 8'($urandom), 0);
        for (int i = 0; i < 224; i++) step(0, 1, 8'h00, 0);

        // Randomized traffic with varying push/pop bias
        for (int ph = 0; ph < 4; ph++) begin
            int unsigned pp, pq;
            pp = (ph % 2 == 0) ? 75 : 30;
            pq = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 400; i++)
                step(($urandom_range(99) < pp), ($urandom_range(99) < pq), 8'($urandom), 0);
        end
        step(0, 0, 8'h00, ($urandom_range(1) == 1));
        for (int i = 0; i < 200; i++)
            step($urandom_range(1) == 1, $urandom_range(1) == 1, 8'($urandom), ($urandom_range(99) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
